// File: rtl/ps2_press_counter_pkg.sv
// Shared scan-code constants, decoder state encoding and small helpers.
// Latency: none (constants and pure functions only).
// Backpressure: none.
package ps2_press_counter_pkg;

    // Scan-code prefixes that steer the decoder rather than name a key
    localparam logic [7:0] SC_BREAK = 8'hF0;
    localparam logic [7:0] SC_EXT   = 8'hE0;

    // Start + 8 data + parity + stop
    localparam logic [3:0] FRAME_BITS = 4'd11;

    typedef enum logic {
        S_MAKE  = 1'b0,
        S_BREAK = 1'b1
    } dec_state_t;

    // Frame is laid out LSB-first as shifted in: [0]=start, [8:1]=data,
    // [9]=odd parity, [10]=stop.
    function automatic logic frame_ok(input logic [10:0] f);
        return (f[0] == 1'b0) && (f[10] == 1'b1) && (^f[9:1] == 1'b1);
    endfunction

    // Saturating-wrap increment: count_max rolls over to zero
    function automatic logic [6:0] count_next(input logic [6:0] c,
                                              input logic [6:0] count_max);
        return (c == count_max) ? 7'd0 : c + 7'd1;
    endfunction

endpackage

// File: rtl/ps2_press_counter_frame_rx.sv
// PS/2 frame receiver: synchronise, detect ps2_clk falls, shift and check 11-bit frames.
// Latency: code/code_valid (or frame_err) one clk after the stop-bit fall is detected.
// Backpressure: none; the keyboard cannot be stalled, results are single-cycle pulses.
module ps2_press_counter_frame_rx
    import ps2_press_counter_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int SYNC_STAGES    = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] code,
    output logic       code_valid,
    output logic       frame_err
);

    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [SYNC_STAGES-1:0] clk_sync;
    logic [SYNC_STAGES-1:0] data_sync;
    logic                   fall;
    logic                   data_bit;
    logic [3:0]             bit_cnt;
    logic [10:0]            shift_q;
    logic [TMO_W-1:0]       tmo_q;

    // Synchroniser chains, idle-high out of reset so no false fall is seen
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_sync  <= '1;
            data_sync <= '1;
        end else begin
            clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
            data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data};
        end
    end

    // Fall is taken between the last two clock stages. Data is taken from
    // the final stage: the keyboard holds data stable well around the fall,
    // so one extra cycle of data lag is harmless.
    assign fall     = clk_sync[SYNC_STAGES-1] & ~clk_sync[SYNC_STAGES-2];
    assign data_bit = data_sync[SYNC_STAGES-1];

    // Bit collection, frame check on the cycle after the 11th bit, and abort
    // of a stalled partial frame
    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt    <= 4'd0;
            shift_q    <= 11'd0;
            tmo_q      <= '0;
            code       <= 8'h00;
            code_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            code_valid <= 1'b0;
            frame_err  <= 1'b0;
            if (bit_cnt == FRAME_BITS) begin
                bit_cnt <= 4'd0;
                tmo_q   <= '0;
                if (frame_ok(shift_q)) begin
                    code       <= shift_q[8:1];
                    code_valid <= 1'b1;
                end else begin
                    frame_err  <= 1'b1;
                end
            end else if (fall) begin
                shift_q <= {data_bit, shift_q[10:1]};
                bit_cnt <= bit_cnt + 4'd1;
                tmo_q   <= '0;
            end else if (bit_cnt != 4'd0) begin
                if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                    frame_err <= 1'b1;
                    bit_cnt   <= 4'd0;
                    tmo_q     <= '0;
                end else begin
                    tmo_q <= tmo_q + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/ps2_press_counter.sv
// PS/2 keyboard press counter: decodes make/break codes, counts distinct presses 0..COUNT_MAX.
// Latency: press_count/cur_key/key_held update one clk after code_valid.
// Backpressure: none; every received byte is consumed on the cycle it is flagged.
module ps2_press_counter
    import ps2_press_counter_pkg::*;
#(
    parameter int COUNT_MAX      = 99,
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int SYNC_STAGES    = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [6:0] press_count,
    output logic [7:0] cur_key,
    output logic       key_held,
    output logic       code_valid,
    output logic [7:0] code,
    output logic       frame_err
);

    dec_state_t state_q, state_d;
    logic [6:0] press_count_d;
    logic [7:0] cur_key_d;
    logic       key_held_d;

    ps2_press_counter_frame_rx #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .SYNC_STAGES    (SYNC_STAGES)
    ) u_frame_rx (
        .clk        (clk),
        .rst        (rst),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .code       (code),
        .code_valid (code_valid),
        .frame_err  (frame_err)
    );

    // Decoder state and press tracking registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_MAKE;
            press_count <= 7'd0;
            cur_key     <= 8'h00;
            key_held    <= 1'b0;
        end else begin
            state_q     <= state_d;
            press_count <= press_count_d;
            cur_key     <= cur_key_d;
            key_held    <= key_held_d;
        end
    end

    // Make/break decode; E0 prefixes pass through without touching state,
    // so extended keys count and release exactly like ordinary ones
    always_comb begin
        state_d       = state_q;
        press_count_d = press_count;
        cur_key_d     = cur_key;
        key_held_d    = key_held;
        if (code_valid && (code != SC_EXT)) begin
            case (state_q)
                S_MAKE: begin
                    if (code == SC_BREAK) begin
                        state_d = S_BREAK;
                    end else if (!key_held || (code != cur_key)) begin
                        press_count_d = count_next(press_count, 7'(COUNT_MAX));
                        cur_key_d     = code;
                        key_held_d    = 1'b1;
                    end
                end
                S_BREAK: begin
                    if (key_held && (code == cur_key)) begin
                        key_held_d = 1'b0;
                    end
                    state_d = S_MAKE;
                end
                default: state_d = S_MAKE;
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_press_counter.sv
// Directed bench for ps2_press_counter: drives PS/2 frames bit by bit and checks decode results.
// Latency: frames take ~11*2*HALF clk each; checks are taken well after each frame settles.
// Backpressure: none.
module tb_ps2_press_counter;

    localparam int TMO  = 200;
    localparam int HALF = 6;

    logic       clk      = 1'b0;
    logic       rst      = 1'b1;
    logic       ps2_clk  = 1'b1;
    logic       ps2_data = 1'b1;
    logic [6:0] press_count;
    logic [7:0] cur_key;
    logic       key_held;
    logic       code_valid;
    logic [7:0] code;
    logic       frame_err;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int valid_cnt   = 0;
    int err_cnt     = 0;
    int pc_chg_cyc  = 0;
    int fall_cyc    = 0;
    int vb, eb;
    logic [6:0] prev_pc = 7'd0;

    ps2_press_counter #(
        .COUNT_MAX      (99),
        .TIMEOUT_CYCLES (TMO),
        .SYNC_STAGES    (3)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .ps2_clk     (ps2_clk),
        .ps2_data    (ps2_data),
        .press_count (press_count),
        .cur_key     (cur_key),
        .key_held    (key_held),
        .code_valid  (code_valid),
        .code        (code),
        .frame_err   (frame_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Pulse counters and press_count change timestamp
    always @(negedge clk) begin
        if (code_valid === 1'b1) valid_cnt++;
        if (frame_err === 1'b1) err_cnt++;
        if (press_count !== prev_pc) pc_chg_cyc = cyc;
        prev_pc = press_count;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [10:0] mk(input logic [7:0] d, input logic bad_par,
                                       input logic bad_stop);
        return {~bad_stop, (~^d) ^ bad_par, d, 1'b0};
    endfunction

    task automatic send_bits(input logic [10:0] f, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            ps2_data = f[i];
            repeat (HALF) @(negedge clk);
            ps2_clk  = 1'b0;
            fall_cyc = cyc;
            repeat (HALF) @(negedge clk);
            ps2_clk  = 1'b1;
        end
        ps2_data = 1'b1;
        repeat (20) @(negedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d);
        send_bits(mk(d, 1'b0, 1'b0), 11);
    endtask

    initial begin
        // Reset state
        repeat (5) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_count",  32'(press_count), 32'd0);
        check("rst_curkey", 32'(cur_key),     32'h00);
        check("rst_held",   32'(key_held),    32'd0);
        check("rst_code",   32'(code),        32'h00);
        check("rst_valid",  32'(code_valid),  32'd0);
        check("rst_err",    32'(frame_err),   32'd0);

        // First press of A
        send(8'h1C);
        check("a_valid_cnt", 32'(valid_cnt),  32'd1);
        check("a_code",      32'(code),       32'h1C);
        check("a_count",     32'(press_count), 32'd1);
        check("a_curkey",    32'(cur_key),    32'h1C);
        check("a_held",      32'(key_held),   32'd1);
        check("a_latency",   32'(pc_chg_cyc - fall_cyc), 32'd5);

        // Typematic repeats and release, then press again
        for (int i = 0; i < 5; i++) send(8'h1C);
        check("rep_count", 32'(press_count), 32'd1);
        check("rep_valid", 32'(valid_cnt),   32'd6);
        send(8'hF0);
        send(8'h1C);
        check("rel_held",  32'(key_held),    32'd0);
        check("rel_count", 32'(press_count), 32'd1);
        send(8'h1C);
        check("again_count", 32'(press_count), 32'd2);
        check("again_held",  32'(key_held),    32'd1);

        // Overlapping keys: 1C held (repeat), 32 pressed, release 32 then 1C
        send(8'h1C);
        check("ovl_rep_count", 32'(press_count), 32'd2);
        send(8'h32);
        check("ovl_count",  32'(press_count), 32'd3);
        check("ovl_curkey", 32'(cur_key),     32'h32);
        check("ovl_held",   32'(key_held),    32'd1);
        send(8'hF0);
        send(8'h32);
        check("ovl_rel32_held", 32'(key_held), 32'd0);
        send(8'hF0);
        send(8'h1C);
        check("ovl_rel1c_held",   32'(key_held),    32'd0);
        check("ovl_rel1c_count",  32'(press_count), 32'd3);
        check("ovl_rel1c_curkey", 32'(cur_key),     32'h32);

        // Extended key press and release through E0 prefixes
        send(8'hE0);
        send(8'h75);
        check("ext_count",  32'(press_count), 32'd4);
        check("ext_curkey", 32'(cur_key),     32'h75);
        send(8'hE0);
        send(8'hF0);
        send(8'h75);
        check("ext_rel_held", 32'(key_held), 32'd0);

        // Bad parity, bad stop, bad start
        eb = err_cnt;
        vb = valid_cnt;
        send_bits(mk(8'h1C, 1'b1, 1'b0), 11);
        send_bits(mk(8'h1C, 1'b0, 1'b1), 11);
        send_bits(mk(8'h1C, 1'b0, 1'b0) | 11'd1, 11);
        check("bad_err_cnt",   32'(err_cnt - eb),   32'd3);
        check("bad_valid_cnt", 32'(valid_cnt - vb), 32'd0);
        check("bad_count",     32'(press_count),    32'd4);

        // Partial frame then silence -> timeout, next frame decodes cleanly
        eb = err_cnt;
        send_bits(mk(8'h1C, 1'b0, 1'b0), 6);
        repeat (TMO + 50) @(negedge clk);
        #1;
        check("tmo_err_cnt", 32'(err_cnt - eb), 32'd1);
        send(8'h1C);
        check("tmo_next_code",  32'(code),          32'h1C);
        check("tmo_next_count", 32'(press_count),   32'd5);
        check("tmo_next_err",   32'(err_cnt - eb),  32'd1);

        // Reset in the middle of a frame
        send_bits(mk(8'h32, 1'b0, 1'b0), 5);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #1;
        check("mid_rst_count",  32'(press_count), 32'd0);
        check("mid_rst_curkey", 32'(cur_key),     32'h00);
        check("mid_rst_held",   32'(key_held),    32'd0);
        check("mid_rst_code",   32'(code),        32'h00);
        eb = err_cnt;
        send(8'h32);
        repeat (TMO + 50) @(negedge clk);
        #1;
        check("post_rst_code",  32'(code),         32'h32);
        check("post_rst_count", 32'(press_count),  32'd1);
        check("post_rst_err",   32'(err_cnt - eb), 32'd0);

        // 100 distinct presses from zero: reach 99 then wrap to 0
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int i = 1; i <= 99; i++) send((i % 2 == 1) ? 8'h1C : 8'h32);
        check("wrap_99", 32'(press_count), 32'd99);
        send(8'h32);
        check("wrap_0",      32'(press_count), 32'd0);
        check("wrap_curkey", 32'(cur_key),     32'h32);
        check("wrap_held",   32'(key_held),    32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
